risc16_dmem: RTL and testbench

RISC16_DMEM -- requirements
Module: risc16_dmem

---
 rtl/risc16_dmem_if.sv | 26 ++
 rtl/risc16_dmem.sv | 145 ++++++++++++++
 tb/tb_risc16_dmem.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc16_dmem_if.sv
// Load/store request and response bundle between a RISC16 core and its data memory.
// Carries no state; timing is set entirely by the responder.
// req_valid/req_ready and rsp_valid/rsp_ready give independent backpressure on each direction.
interface risc16_dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_rdata;
   logic        rsp_err;

   // Core side: issues requests, consumes responses
   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   // Memory side: accepts requests, produces responses
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/risc16_dmem.sv
// 256 x 16 word-addressed data memory with one outstanding load/store (optional write protect: RISC16_DMEM_WPROT_EN).
// Latency: access happens WAIT_CYCLES edges after acceptance; response is valid right after the access edge.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready, with no accept on that edge.
module risc16_dmem #(
   parameter int         WAIT_CYCLES = 2,
   parameter logic [7:0] PROT_BASE   = 8'hF0
) (
   input  logic           clk,
   input  logic           rst_n,
   risc16_dmem_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Counter start value; a zero-wait build never enters WAIT so the value is irrelevant there
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic        we_q,    we_d;
   logic [7:0]  addr_q,  addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        err_q,   err_d;

   // Storage is deliberately outside the reset domain so contents survive rst_n
   logic [15:0] mem_q [256];

   // Access strobe and the operands it acts on (live inputs for zero-wait, latched copy otherwise)
   logic        acc_en;
   logic        acc_we;
   logic [7:0]  acc_addr;
   logic [15:0] acc_wdata;
   logic        acc_prot;
   logic        mem_we;

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;

   // Sequencing: accept in IDLE, count down in WAIT, hold the response in RESP
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      acc_en    = 1'b0;
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               if (WAIT_CYCLES == 0) begin
                  acc_en    = 1'b1;
                  acc_we    = bus.req_we;
                  acc_addr  = bus.req_addr;
                  acc_wdata = bus.req_wdata;
                  state_d   = RESP;
               end else begin
                  cnt_d   = WAIT_INIT;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               acc_en  = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Access result: load data or zero for stores, error flag, and the array write strobe
   always_comb begin
`ifdef RISC16_DMEM_WPROT_EN
      acc_prot = acc_we && (acc_addr >= PROT_BASE);
`else
      acc_prot = 1'b0;
`endif
      rdata_d = rdata_q;
      err_d   = err_q;
      if (acc_en) begin
         rdata_d = acc_we ? 16'h0000 : mem_q[acc_addr];
         err_d   = acc_prot;
      end
      // Gating with rst_n keeps a store from landing while reset is held
      mem_we = acc_en && acc_we && !acc_prot && rst_n;
   end

   // Control and response registers; reset abandons any in-flight access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Array write port
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[acc_addr] <= acc_wdata;
      end
   end

`ifdef RISC16_DMEM_WPROT_EN
   assign bus.rsp_err = err_q;
`else
   // Protection disabled: error output is hard-wired low and the threshold has no effect
   logic unused_prot;
   assign unused_prot   = ^{PROT_BASE, err_q};
   assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_risc16_dmem.sv
// Bench for risc16_dmem: directed table, hand-written corner sequences and random traffic vs a model.
// Uses a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance sharing clock and reset.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_risc16_dmem;

   localparam logic [7:0] TB_PROT = 8'hF0;

   logic clk;
   logic rst_n;

   risc16_dmem_if b2 ();
   risc16_dmem_if b0 ();

   risc16_dmem #(.WAIT_CYCLES(2), .PROT_BASE(TB_PROT)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b2)
   );

   risc16_dmem #(.WAIT_CYCLES(0), .PROT_BASE(TB_PROT)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model of the array contents as seen through the WAIT_CYCLES=2 instance
   logic [15:0] mm [256];
   bit          mk [256];

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic drive(input int w, input logic v, input logic we, input logic [7:0] a, input logic [15:0] d);
      if (w == 0) begin
         b0.req_valid = v; b0.req_we = we; b0.req_addr = a; b0.req_wdata = d;
      end else begin
         b2.req_valid = v; b2.req_we = we; b2.req_addr = a; b2.req_wdata = d;
      end
   endtask

   task automatic set_rr(input int w, input logic v);
      if (w == 0) b0.rsp_ready = v;
      else        b2.rsp_ready = v;
   endtask

   function automatic logic g_rdy(input int w);
      return (w == 0) ? b0.req_ready : b2.req_ready;
   endfunction

   function automatic logic g_rv(input int w);
      return (w == 0) ? b0.rsp_valid : b2.rsp_valid;
   endfunction

   function automatic logic [15:0] g_rd(input int w);
      return (w == 0) ? b0.rsp_rdata : b2.rsp_rdata;
   endfunction

   function automatic logic g_err(input int w);
      return (w == 0) ? b0.rsp_err : b2.rsp_err;
   endfunction

   // Model: what a transaction must return, and its effect on the array
   task automatic model_apply(input logic we, input logic [7:0] a, input logic [15:0] d,
                              output logic [15:0] er, output logic ee, output bit ek);
      if (we) begin
         er = 16'h0000;
         ek = 1'b1;
`ifdef RISC16_DMEM_WPROT_EN
         ee = (a >= TB_PROT);
`else
         ee = 1'b0;
`endif
         if (!ee) begin
            mm[a] = d;
            mk[a] = 1'b1;
         end
      end else begin
         ee = 1'b0;
         er = mm[a];
         ek = mk[a];
      end
   endtask

   // One full transaction; starts and ends just after a falling edge
   task automatic do_txn(input int w, input logic we, input logic [7:0] a, input logic [15:0] d,
                         input int hold, output logic [15:0] rdata, output logic err, output int lat);
      int n;
      logic [15:0] r0;
      logic e0;
      rdata = 16'hxxxx;
      err   = 1'bx;
      lat   = -1;
      drive(w, 1'b1, we, a, d);
      n = 0;
      while (!g_rdy(w) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         fail_now("accept");
         drive(w, 1'b0, 1'b0, 8'h00, 16'h0000);
         return;
      end
      @(posedge clk);
      @(negedge clk);
      // Scramble request fields: the DUT must work from what it latched
      drive(w, 1'b0, 1'($urandom), 8'($urandom), 16'($urandom));
      lat = 0;
      while (!g_rv(w) && lat < 20) begin
         chk("busy_req_ready", 32'(g_rdy(w)), 32'd0);
         @(negedge clk);
         lat++;
      end
      if (lat >= 20) begin
         fail_now("rsp_valid");
         return;
      end
      chk("resp_req_ready", 32'(g_rdy(w)), 32'd0);
      r0 = g_rd(w);
      e0 = g_err(w);
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", 32'(g_rv(w)), 32'd1);
         chk("hold_rdata", 32'(g_rd(w)), 32'(r0));
         chk("hold_err",   32'(g_err(w)), 32'(e0));
      end
      set_rr(w, 1'b1);
      @(negedge clk);
      set_rr(w, 1'b0);
      chk("post_hs_valid", 32'(g_rv(w)), 32'd0);
      rdata = r0;
      err   = e0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [10];
      logic [15:0] rd, er, v_f5;
      logic        e, ee;
      bit          ek;
      int          lat;

      tbl[0] = '{1'b1, 8'h10, 16'hBEEF, 16'h0000, 1'b0};
      tbl[1] = '{1'b0, 8'h10, 16'h0000, 16'hBEEF, 1'b0};
      tbl[2] = '{1'b1, 8'h20, 16'h5555, 16'h0000, 1'b0};
      tbl[3] = '{1'b0, 8'h20, 16'h0000, 16'h5555, 1'b0};
      tbl[4] = '{1'b1, 8'hEF, 16'h1234, 16'h0000, 1'b0};
      tbl[5] = '{1'b0, 8'hEF, 16'hFFFF, 16'h1234, 1'b0};
      tbl[6] = '{1'b1, 8'h00, 16'hFFFF, 16'h0000, 1'b0};
      tbl[7] = '{1'b1, 8'h01, 16'h0001, 16'h0000, 1'b0};
      tbl[8] = '{1'b0, 8'h00, 16'h0000, 16'hFFFF, 1'b0};
      tbl[9] = '{1'b0, 8'h10, 16'h0000, 16'hBEEF, 1'b0};

      for (int i = 0; i < 256; i++) begin
         mm[i] = 16'h0000;
         mk[i] = 1'b0;
      end

      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      drive(2, 1'b0, 1'b0, 8'h00, 16'h0000);
      set_rr(0, 1'b0);
      set_rr(2, 1'b0);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(b2.req_ready), 32'd1);
      chk("rst_rdata",     32'(b2.rsp_rdata), 32'd0);
      chk("rst_err",       32'(b2.rsp_err),   32'd0);
      chk("rst0_req_ready", 32'(b0.req_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table on the two-wait instance
      for (int i = 0; i < 10; i++) begin
         do_txn(2, tbl[i].we, tbl[i].addr, tbl[i].wdata, i % 3, rd, e, lat);
         model_apply(tbl[i].we, tbl[i].addr, tbl[i].wdata, er, ee, ek);
         chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rdata));
         chk($sformatf("tbl%0d_err", i),   32'(e),  32'(tbl[i].exp_err));
         chk($sformatf("tbl%0d_lat", i),   32'(lat), 32'd2);
      end

      // Response stall with a new request waiting behind it
      do_txn(2, 1'b1, 8'h30, 16'h1234, 0, rd, e, lat);
      model_apply(1'b1, 8'h30, 16'h1234, er, ee, ek);
      drive(2, 1'b1, 1'b0, 8'h30, 16'h0000);
      chk("stall_ready0", 32'(b2.req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      drive(2, 1'b1, 1'b0, 8'h10, 16'h0000);
      lat = 0;
      while (!b2.rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("stall_lat",   32'(lat), 32'd2);
      chk("stall_rdata", 32'(b2.rsp_rdata), 32'h1234);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stall_valid", 32'(b2.rsp_valid), 32'd1);
         chk("stall_rdata_hold", 32'(b2.rsp_rdata), 32'h1234);
         chk("stall_no_accept", 32'(b2.req_ready), 32'd0);
      end
      set_rr(2, 1'b1);
      @(negedge clk);
      set_rr(2, 1'b0);
      chk("hs_valid_drop", 32'(b2.rsp_valid), 32'd0);
      chk("hs_not_accepted", 32'(b2.req_ready), 32'd1);
      @(negedge clk);
      chk("accept_after_hs", 32'(b2.req_ready), 32'd0);
      drive(2, 1'b0, 1'b0, 8'h00, 16'h0000);
      lat = 0;
      while (!b2.rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 20) fail_now("queued_rsp");
      chk("queued_rdata", 32'(b2.rsp_rdata), 32'hBEEF);
      set_rr(2, 1'b1);
      @(negedge clk);
      set_rr(2, 1'b0);

      // Reset during WAIT discards the pending store
      drive(2, 1'b1, 1'b1, 8'h20, 16'hAAAA);
      @(posedge clk);
      @(negedge clk);
      drive(2, 1'b0, 1'b0, 8'h00, 16'h0000);
      chk("pre_rst_busy", 32'(b2.req_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(b2.rsp_valid), 32'd0);
      chk("midrst_ready", 32'(b2.req_ready), 32'd1);
      repeat (3) begin
         @(negedge clk);
         chk("midrst_valid_hold", 32'(b2.rsp_valid), 32'd0);
         chk("midrst_rdata", 32'(b2.rsp_rdata), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      do_txn(2, 1'b0, 8'h20, 16'h0000, 0, rd, e, lat);
      chk("rst_discard_rdata", 32'(rd), 32'h5555);

      // Protected-region behaviour
      do_txn(2, 1'b0, 8'hF5, 16'h0000, 0, v_f5, e, lat);
      do_txn(2, 1'b1, 8'hF5, 16'h7777, 1, rd, e, lat);
      model_apply(1'b1, 8'hF5, 16'h7777, er, ee, ek);
`ifdef RISC16_DMEM_WPROT_EN
      chk("prot_err", 32'(e), 32'd1);
`else
      chk("prot_err", 32'(e), 32'd0);
`endif
      chk("prot_store_rdata", 32'(rd), 32'd0);
      chk("prot_lat", 32'(lat), 32'd2);
      do_txn(2, 1'b0, 8'hF5, 16'h0000, 0, rd, e, lat);
`ifdef RISC16_DMEM_WPROT_EN
      chk("prot_load", 32'(rd), 32'(v_f5));
`else
      chk("prot_load", 32'(rd), 32'h7777);
`endif
      chk("prot_load_err", 32'(e), 32'd0);
      do_txn(2, 1'b1, 8'hEF, 16'h4321, 0, rd, e, lat);
      model_apply(1'b1, 8'hEF, 16'h4321, er, ee, ek);
      chk("below_prot_err", 32'(e), 32'd0);
      do_txn(2, 1'b0, 8'hEF, 16'h0000, 0, rd, e, lat);
      chk("below_prot_load", 32'(rd), 32'h4321);

      // Random traffic against the model
      for (int i = 0; i < 200; i++) begin
         logic        rwe;
         logic [7:0]  ra;
         logic [15:0] rdd;
         rwe = 1'($urandom);
         case ($urandom_range(0, 3))
            0:       ra = 8'($urandom);
            1:       ra = 8'hEC + 8'($urandom_range(0, 7));
            default: ra = 8'h40 + 8'($urandom_range(0, 15));
         endcase
         rdd = 16'($urandom);
         do_txn(2, rwe, ra, rdd, $urandom_range(0, 3), rd, e, lat);
         model_apply(rwe, ra, rdd, er, ee, ek);
         if (ek) chk($sformatf("rnd%0d_rdata", i), 32'(rd), 32'(er));
         chk($sformatf("rnd%0d_err", i), 32'(e), 32'(ee));
         chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd2);
      end

      // Zero-wait instance
      do_txn(0, 1'b1, 8'h05, 16'hCAFE, 1, rd, e, lat);
      chk("w0_store_lat",   32'(lat), 32'd0);
      chk("w0_store_rdata", 32'(rd),  32'd0);
      do_txn(0, 1'b0, 8'h05, 16'h0000, 2, rd, e, lat);
      chk("w0_load_lat",   32'(lat), 32'd0);
      chk("w0_load_rdata", 32'(rd),  32'hCAFE);
      chk("w0_load_err",   32'(e),   32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
